// File: rtl/dxi_filter_arbiter.sv
// dxi_filter_arbiter: round-robin arbiter sharing one DXI filter between NUM_REQ requesters, one transaction in flight with timeout error response
module dxi_filter_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int OW = $clog2(NUM_REQ),
    localparam int CW = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [NUM_REQ*72-1:0] i_req_data,
    input  logic [NUM_REQ*2-1:0] i_req_cfg,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic                 o_dxi_valid,
    output logic [71:0]          o_dxi_data,
    output logic [1:0]           o_config_select,
    input  logic                 i_dxi_ready,
    input  logic                 i_dxi_out_valid,
    input  logic [7:0]           i_master_data,
    output logic                 o_dxi_out_ready,
    output logic [NUM_REQ-1:0]   o_rsp_valid,
    output logic [7:0]           o_rsp_data,
    output logic                 o_rsp_err,
    input  logic [NUM_REQ-1:0]   i_rsp_ready,
    output logic                 o_busy,
    output logic [OW-1:0]        o_owner
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DELIVER} state_t;
    state_t state;
    logic [OW-1:0] rr_ptr;
    logic [OW-1:0] gnt;
    logic gnt_ok;
    logic [CW-1:0] cnt;
    always_comb begin
        gnt_ok = 1'b0;
        gnt = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
                gnt_ok = 1'b1;
                gnt = OW'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end
    assign o_req_ready     = (state == IDLE && gnt_ok && i_rstn) ? NUM_REQ'(1) << gnt : '0;
    assign o_dxi_valid     = state == ISSUE;
    assign o_dxi_out_ready = state == WAIT_RSP;
    assign o_rsp_valid     = (state == DELIVER) ? NUM_REQ'(1) << o_owner : '0;
    assign o_busy          = state != IDLE;
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            o_owner         <= '0;
            o_dxi_data      <= '0;
            o_config_select <= '0;
            o_rsp_data      <= '0;
            o_rsp_err       <= 1'b0;
            cnt             <= '0;
        end else begin
            case (state)
                IDLE: if (gnt_ok) begin
                    o_dxi_data      <= i_req_data[int'(gnt)*72 +: 72];
                    o_config_select <= i_req_cfg[int'(gnt)*2 +: 2];
                    o_owner         <= gnt;
                    state           <= ISSUE;
                end
                ISSUE: if (i_dxi_ready) begin
                    cnt   <= '0;
                    state <= WAIT_RSP;
                end
                WAIT_RSP: begin
                    cnt <= cnt + 1'b1;
                    if (i_dxi_out_valid) begin
                        o_rsp_data <= i_master_data;
                        o_rsp_err  <= 1'b0;
                        state      <= DELIVER;
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        o_rsp_data <= '0;
                        o_rsp_err  <= 1'b1;
                        state      <= DELIVER;
                    end
                end
                DELIVER: if (i_rsp_ready[o_owner]) begin
                    rr_ptr <= (o_owner == OW'(NUM_REQ - 1)) ? '0 : o_owner + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dxi_filter_arbiter.md
Name: dxi_filter_arbiter

Overview:
Round-robin arbiter that shares one 3x3 DXI filter (dxi_top) between NUM_REQ independent window requesters. It accepts one 72-bit window plus 2-bit config from the granted requester and drives the filter's DXI input and config_select. It collects the 8-bit filter result and routes it back to the owning requester. Exactly one transaction is in flight; a timeout guarantees every accepted request receives a response.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 256, max cycles in WAIT_RSP before forced error response (>=2)

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset; synchronous, active-low
i_req_valid  in  NUM_REQ  per-requester window valid
i_req_data  in  NUM_REQ*72  window of requester k at [k*72 +: 72]
i_req_cfg  in  NUM_REQ*2  config of requester k at [k*2 +: 2]
o_req_ready  out  NUM_REQ  one-hot accept
o_dxi_valid  out  1  to filter i_dxi_valid
o_dxi_data  out  72  to filter i_dxi_data
o_config_select  out  2  to filter config_select
i_dxi_ready  in  1  from filter o_dxi_ready
i_dxi_out_valid  in  1  from filter o_dxi_out_valid
i_master_data  in  8  from filter o_master_data
o_dxi_out_ready  out  1  to filter i_dxi_out_ready
o_rsp_valid  out  NUM_REQ  one-hot response valid
o_rsp_data  out  8  response pixel (shared bus)
o_rsp_err  out  1  response is a timeout error, data forced to 0
i_rsp_ready  in  NUM_REQ  per-requester response ready
o_busy  out  1  high in any state except IDLE
o_owner  out  $clog2(NUM_REQ)  index of current/last owner

Behaviour:
- Reset (i_rstn=0 at posedge): state=IDLE, rr_ptr=0, all outputs 0, data/cfg/rsp regs 0, timeout counter 0. Reset mid-transaction drops it silently; no response issued.
- FSM states: IDLE, ISSUE, WAIT_RSP, DELIVER.
- IDLE: grant g = first k with i_req_valid[k], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. o_req_ready[g]=1 combinationally in the same cycle (all other ready bits 0; none if no valid). On that edge capture data/cfg, o_owner<=g, -> ISSUE.
- ISSUE: o_dxi_valid=1, o_dxi_data=captured window. Held stable until i_dxi_ready=1 at a posedge, then -> WAIT_RSP. Valid is never retracted.
- o_config_select = captured cfg from entry into ISSUE until leaving WAIT_RSP; holds its last value in DELIVER/IDLE (filter may sample late).
- WAIT_RSP: o_dxi_out_ready=1 (0 in all other states). Counter increments each cycle from 0. i_dxi_out_valid=1 -> capture i_master_data, err=0, -> DELIVER. Otherwise, counter==TIMEOUT_CYCLES-1 -> data=0, err=1, -> DELIVER. If valid and timeout occur in the same cycle, valid wins (err=0).
- DELIVER: o_rsp_valid[o_owner]=1, o_rsp_data/o_rsp_err held. On i_rsp_ready[o_owner]=1 -> IDLE, rr_ptr <= (o_owner+1) mod NUM_REQ. Ready bits of non-owners are ignored.
- Latency, filter instantly ready and responsive: request accepted at cycle 0, o_dxi_valid at cycle 1, response valid 1 cycle after i_dxi_out_valid. Minimum 4 cycles between grants.
- A requester may drop i_req_valid before grant; no state change results. A requester whose valid stays high is served within NUM_REQ transactions (no starvation).
- i_dxi_out_valid outside WAIT_RSP is ignored.

Test Plan:
- Single request: req1 data=72'hFFFFFFFFFFFFFFFFFF cfg=2'b10, filter returns 8'hFF -> o_req_ready=4'b0010 for one cycle, o_config_select=2'b10, o_rsp_valid=4'b0010, o_rsp_data=8'hFF, o_rsp_err=0, o_owner=1.
- Simultaneous: req0 and req2 valid from reset with req0=72'hA5..A5 cfg=11 (filter -> A5) and req2=72'h00..08 cfg=00 (filter -> 00) -> req0 served first (data A5), then req2 (data 00).
- Fairness: all 4 valid continuously, each response acknowledged immediately -> grant order 0,1,2,3,0,1; no index skipped.
- Backpressure: i_dxi_ready low 5 cycles in ISSUE -> o_dxi_valid and o_dxi_data stable all 5 cycles. i_rsp_ready low 3 cycles in DELIVER -> o_rsp_valid and o_rsp_data stable, no new grant.
- Timeout: TIMEOUT_CYCLES=8, filter never asserts out_valid -> exactly 8 cycles in WAIT_RSP, then o_rsp_err=1, o_rsp_data=0; the next request is served normally.
- Reset in WAIT_RSP: i_rstn=0 for 1 cycle -> all outputs 0, o_busy=0, no o_rsp_valid issued; the next grant goes to requester 0.
